// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, stop-length tick counts and the
// receiver state encoding.
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  // Stop period expressed in 16x oversample ticks.
  localparam int STOP_1   = 16;
  localparam int STOP_1P5 = 24;
  localparam int STOP_2   = 32;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_START   = 3'd1,
    ST_DATA    = 3'd2,
    ST_PAR     = 3'd3,
    ST_STOP    = 3'd4,
    ST_WAIT_HI = 3'd5
  } rx_state_t;

endpackage

// File: rtl/uart_baud_gen.sv
// Free-running oversample tick generator shared by the UART receiver and
// transmitter; s_tick pulses once every CLK_DIV cycles.
module uart_baud_gen #(
  parameter int CLK_DIV = 326
) (
  input  logic clk,
  input  logic reset,
  output logic s_tick
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Decoded straight from the counter so the tick never lags the wrap.
  assign s_tick = (cnt == CNT_LAST);

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: oversampled start/data/parity/stop capture
// feeding a one-entry holding register with read acknowledge.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int DBIT       = 8,
  parameter int OVERSAMPLE = 16,
  parameter int SB_TICK    = 16,
  parameter int CLK_DIV    = 326,
  parameter int PARITY     = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            rx,
  input  logic            rd,
  output logic [DBIT-1:0] dout,
  output logic            rx_valid,
  output logic            parity_err,
  output logic            frame_err,
  output logic            overrun_err,
  output logic            rx_done_tick,
  output logic            s_tick
);

  localparam int SMAX = (SB_TICK > OVERSAMPLE) ? SB_TICK : OVERSAMPLE;
  localparam int SW   = $clog2(SMAX);
  localparam int NW   = $clog2(DBIT + 1);

  localparam logic [SW-1:0] S_HALF = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] S_BIT  = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0] S_STOP = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);

  localparam logic PAR_ON       = (PARITY != PAR_NONE);
  localparam logic PAR_ODD_MODE = (PARITY == PAR_ODD);

  function automatic logic parity_fail(input logic [DBIT-1:0] d, input logic pbit);
    return ((^d) ^ pbit) != PAR_ODD_MODE;
  endfunction

  rx_state_t       state;
  logic [SW-1:0]   s;
  logic [NW-1:0]   n;
  logic            rx_meta;
  logic            rx_s;
  logic [DBIT-1:0] shreg;
  logic            frame_perr;
  logic            frame_ferr;
  logic            bit_smp;
  logic            par_smp;
  logic            stop_smp;
  logic            take_new;

  uart_baud_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_baud (
    .clk    (clk),
    .reset  (reset),
    .s_tick (s_tick)
  );

  // Stage 0: two-flop synchroniser, idles high so reset never looks like a start.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  assign bit_smp  = (state == ST_DATA) && s_tick && (s == S_BIT);
  assign par_smp  = (state == ST_PAR)  && s_tick && (s == S_BIT);
  assign stop_smp = (state == ST_STOP) && s_tick && (s == S_STOP);

  // Stage 1: frame FSM; rx_done_tick is registered off the stop sample.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      s            <= '0;
      n            <= '0;
      rx_done_tick <= 1'b0;
    end else begin
      rx_done_tick <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (!rx_s) begin
            state <= ST_START;
            s     <= '0;
          end
        end
        ST_START: begin
          if (s_tick) begin
            if (s == S_HALF) begin
              if (rx_s) begin
                state <= ST_IDLE;
              end else begin
                state <= ST_DATA;
                s     <= '0;
                n     <= '0;
              end
            end else begin
              s <= s + 1'b1;
            end
          end
        end
        ST_DATA: begin
          if (s_tick) begin
            if (s == S_BIT) begin
              s <= '0;
              if (n == N_LAST) begin
                state <= PAR_ON ? ST_PAR : ST_STOP;
              end else begin
                n <= n + 1'b1;
              end
            end else begin
              s <= s + 1'b1;
            end
          end
        end
        ST_PAR: begin
          if (s_tick) begin
            if (s == S_BIT) begin
              s     <= '0;
              state <= ST_STOP;
            end else begin
              s <= s + 1'b1;
            end
          end
        end
        ST_STOP: begin
          if (s_tick) begin
            if (s == S_STOP) begin
              rx_done_tick <= 1'b1;
              // A low stop sample is a break or misframe: wait for the line to recover.
              state        <= rx_s ? ST_IDLE : ST_WAIT_HI;
            end else begin
              s <= s + 1'b1;
            end
          end
        end
        ST_WAIT_HI: begin
          if (rx_s) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Frame datapath: shift register and per-frame error bits, no reset needed.
  always_ff @(posedge clk) begin
    if (bit_smp) begin
      shreg <= {rx_s, shreg[DBIT-1:1]};
    end
    if (state == ST_START) begin
      frame_perr <= 1'b0;
    end else if (par_smp) begin
      frame_perr <= parity_fail(shreg, rx_s);
    end
    if (stop_smp) begin
      frame_ferr <= ~rx_s;
    end
  end

  assign take_new = !rx_valid || rd;

  // Stage 2: holding register, updated in the rx_done_tick cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      dout        <= '0;
      rx_valid    <= 1'b0;
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
    end else if (rx_done_tick) begin
      if (take_new) begin
        dout       <= shreg;
        parity_err <= frame_perr;
        frame_err  <= frame_ferr;
        rx_valid   <= 1'b1;
        if (rd) begin
          overrun_err <= 1'b0;
        end
      end else begin
        overrun_err <= 1'b1;
      end
    end else if (rd && rx_valid) begin
      rx_valid    <= 1'b0;
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
    end
  end

endmodule

// File: doc/uart_rx_param.md
Name: uart_rx_param

Overview:
Parametrised UART receiver, the next generation of the team's fixed 8N1 receive path. It has an internal baud-tick generator, configurable data width, parity and stop length, and a one-entry holding register with a read handshake. It reports parity, framing and overrun errors. It sits beside the UART transmitter in the uart top level and is driven from the serial input pin.

Parameters:
- DBIT, 8, data bits per frame (5..9), sent LSB first.
- OVERSAMPLE, 16, s_tick pulses per bit period (even, >=8).
- SB_TICK, 16, s_tick pulses in the stop period: 16 = 1 stop bit, 24 = 1.5, 32 = 2.
- CLK_DIV, 326, clk cycles per s_tick (>=2).
- PARITY, 0, parity mode: 0 none, 1 odd, 2 even.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- rx  in  1  asynchronous serial input; idles high.
- rd  in  1  consumer acknowledge; pops the holding register when rx_valid=1.
- dout  out  DBIT  held received data.
- rx_valid  out  1  holding register contains an unread byte.
- parity_err  out  1  held byte failed its parity check.
- frame_err  out  1  held byte's stop sample was 0.
- overrun_err  out  1  sticky; a frame was lost because the holding register was full.
- rx_done_tick  out  1  one-cycle pulse at the end of every completed frame.
- s_tick  out  1  oversample tick from the baud generator.

Behaviour:
- Reset values: dout=0, rx_valid=0, parity_err=0, frame_err=0, overrun_err=0, rx_done_tick=0, s_tick=0. The FSM goes to IDLE and the synchroniser flops are set to 1.
- Reset mid-frame abandons the frame; no rx_done_tick is produced.
- Baud generator:
  - Counter runs 0..CLK_DIV-1 and wraps.
  - s_tick=1 for exactly one cycle when the counter equals CLK_DIV-1.
  - The counter is free-running and is not re-phased by a start bit.
- Input: two-flop synchroniser; the FSM uses only the synchronised rx_s. This gives 2 cycles of input latency.
- FSM states and counters: IDLE, START, DATA, PAR, STOP, WAIT_HI. s is the tick counter; n is the bit counter.
  - IDLE: rx_s=0 -> START with s=0.
  - START: on s_tick, if s=OVERSAMPLE/2-1, sample the line:
    - rx_s=0 -> DATA with s=0, n=0.
    - rx_s=1 -> IDLE (glitch rejection, no flags).
    - Otherwise s++.
  - DATA: on s_tick, if s=OVERSAMPLE-1:
    - Shift rx_s into the MSB of the shift register (LSB-first assembly) and set s=0.
    - If n=DBIT-1, go to PAR when PARITY!=0, else to STOP. Otherwise n++.
  - PAR: sample at s=OVERSAMPLE-1. perr = (XOR of data XOR parity bit) != (PARITY==1).
  - STOP: sample at s=SB_TICK-1. ferr = ~rx_s, then the frame completes:
    - If ferr=0, go to IDLE.
    - If ferr=1 (break or misframe), go to WAIT_HI and stay there until rx_s=1, then go to IDLE.
- Frame completion (registered): rx_done_tick rises the cycle after the final stop-sample tick cycle.
- Holding register updates in the same cycle as rx_done_tick:
  - rx_valid=0: load dout, parity_err, frame_err; set rx_valid=1.
  - rx_valid=1 and rd=0: discard the new frame, keep the old byte and flags, set overrun_err=1.
  - rx_valid=1 and rd=1: the old byte is consumed, the new one is loaded, rx_valid stays 1, no overrun.
- rd with rx_valid=1 and no completion: clears rx_valid, parity_err, frame_err, overrun_err next cycle. dout holds its last value.
- rd with rx_valid=0: ignored.
- Errored bytes (parity or frame) are still delivered, with their flags set.

Decomposition:
- Package uart_pkg holds:
  - parity-mode constants PAR_NONE, PAR_ODD, PAR_EVEN;
  - the FSM state enumeration (3-bit encoding);
  - stop-length constants STOP_1=16, STOP_1P5=24, STOP_2=32.
- Sub-module uart_baud_gen, parameter CLK_DIV, ports clk, reset, s_tick. It is shared with the transmitter.

Test Plan:
- Sim parameters for every scenario: CLK_DIV=4, OVERSAMPLE=16, DBIT=8, PARITY=2, SB_TICK=16. The line is driven at 64 clk per bit.
- Nominal frame: send 0xB2 with even parity bit 0 and stop 1 -> one rx_done_tick; dout=0xB2, rx_valid=1, all error flags 0. rd pulse -> rx_valid=0 next cycle.
- Parity error: send 0xB2 with parity bit 1 -> dout=0xB2, parity_err=1, frame_err=0.
- Framing error / break: hold rx=0 for 12 bit periods -> frame_err=1, dout=0x00, exactly one rx_done_tick. No new start is detected until rx returns high.
- Overrun and simultaneous events:
  - Two back-to-back frames 0x55 then 0xAA with no rd -> dout=0x55, overrun_err=1.
  - Repeat with rd asserted in the second rx_done_tick cycle -> dout=0xAA, overrun_err=0.
- Glitch and reset:
  - 20-clk low pulse on rx -> returns to IDLE, no rx_done_tick.
  - Assert reset mid-DATA of 0x3C -> all outputs 0, no tick. A following 0x3C frame is received correctly.
